// File: rtl/aes_vector_checker.sv
// rtl/aes_vector_checker.sv - multi-vector self-checking player for an AES core
//
// Holds DEPTH {plaintext, key, expected ciphertext} slots. On start, the first
// N slots are streamed into the core one per cycle. Each result is compared
// CORE_LAT cycles later against the slot's expected value. The block reports
// pass/fail counts and the first failing slot.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data,
//   wr_key, wr_exp                 slot load (ignored while busy)
//   num_vec, start                 run length (clamped to DEPTH) and launch
//   core_data, core_key,
//   core_valid                     vector presented to the core
//   core_result                    core output
//   busy, done                     run status
//   pass_cnt, fail_cnt             compare counts of the current/last run
//   mismatch                       one-cycle pulse per failing compare
//   first_fail_idx, first_fail_vld earliest failing slot of the run
module aes_vector_checker #(
  parameter int DATA_W   = 128,
  parameter int KEY_W    = 128,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int CORE_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [DATA_W-1:0] wr_exp,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              start,
  output logic [DATA_W-1:0] core_data,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_valid,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pass_cnt,
  output logic [ADDR_W:0]   fail_cnt,
  output logic              mismatch,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_vld
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  // Vector memory: no reset, contents survive rst.
  logic [DATA_W-1:0] mem_pt_q  [DEPTH];
  logic [KEY_W-1:0]  mem_key_q [DEPTH];
  logic [DATA_W-1:0] mem_exp_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] last_q, last_d;       // index of the final slot of the run
  logic [ADDR_W-1:0] cur_idx_q, cur_idx_d; // slot currently on the core bus
  logic              core_valid_q, core_valid_d;
  logic [DATA_W-1:0] core_data_q, core_data_d;
  logic [KEY_W-1:0]  core_key_q, core_key_d;
  logic [ADDR_W:0]   pass_q, pass_d;
  logic [ADDR_W:0]   fail_q, fail_d;
  logic              mismatch_q, mismatch_d;
  logic [ADDR_W-1:0] ff_idx_q, ff_idx_d;
  logic              ff_vld_q, ff_vld_d;

  logic              wr_fire;
  logic [ADDR_W:0]   n_clamp;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_idx;
  logic              cmp_match;
  logic              last_cmp;
  logic              load;
  logic [ADDR_W-1:0] load_idx;

  assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign wr_fire = wr_en && !busy;
  assign n_clamp = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_pt_q[wr_addr]  <= wr_data;
      mem_key_q[wr_addr] <= wr_key;
      mem_exp_q[wr_addr] <= wr_exp;
    end
  end

  // Latency alignment: the valid bit and slot index travel alongside the core
  // so the compare sees the right expected value when the result emerges.
  generate
    if (CORE_LAT == 0) begin : g_comb_core
      assign cmp_vld = core_valid_q;
      assign cmp_idx = cur_idx_q;
    end else begin : g_piped_core
      logic [CORE_LAT-1:0] vld_pipe_q;
      logic [ADDR_W-1:0]   idx_pipe_q [CORE_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe_q <= '0;
          for (int s = 0; s < CORE_LAT; s++) begin
            idx_pipe_q[s] <= '0;
          end
        end else begin
          vld_pipe_q[0] <= core_valid_q;
          idx_pipe_q[0] <= cur_idx_q;
          for (int s = 1; s < CORE_LAT; s++) begin
            vld_pipe_q[s] <= vld_pipe_q[s-1];
            idx_pipe_q[s] <= idx_pipe_q[s-1];
          end
        end
      end

      assign cmp_vld = vld_pipe_q[CORE_LAT-1];
      assign cmp_idx = idx_pipe_q[CORE_LAT-1];
    end
  endgenerate

  assign cmp_match = (core_result == mem_exp_q[cmp_idx]);
  assign last_cmp  = cmp_vld && (cmp_idx == last_q);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cur_idx_d    = cur_idx_q;
    core_valid_d = 1'b0;
    core_data_d  = core_data_q;
    core_key_d   = core_key_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    mismatch_d   = 1'b0;
    ff_idx_d     = ff_idx_q;
    ff_vld_d     = ff_vld_q;
    load         = 1'b0;
    load_idx     = '0;

    if (cmp_vld) begin
      if (cmp_match) begin
        pass_d = pass_q + (ADDR_W+1)'(1);
      end else begin
        fail_d     = fail_q + (ADDR_W+1)'(1);
        mismatch_d = 1'b1;
        if (!ff_vld_q) begin
          ff_idx_d = cmp_idx;
          ff_vld_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_d   = '0;
          fail_d   = '0;
          ff_idx_d = '0;
          ff_vld_d = 1'b0;
          last_d   = n_clamp[ADDR_W-1:0] - ADDR_W'(1);
          if (n_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            load    = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (cur_idx_q == last_q) begin
          // With a combinational core the final compare happens in the
          // final issue cycle, so the drain phase is skipped entirely.
          state_d = last_cmp ? S_DONE : S_DRAIN;
        end else begin
          load     = 1'b1;
          load_idx = cur_idx_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (last_cmp) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      core_valid_d = 1'b1;
      cur_idx_d    = load_idx;
      // A write landing on the same edge as the start must be seen by the run.
      if (wr_fire && (wr_addr == load_idx)) begin
        core_data_d = wr_data;
        core_key_d  = wr_key;
      end else begin
        core_data_d = mem_pt_q[load_idx];
        core_key_d  = mem_key_q[load_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= '0;
      cur_idx_q    <= '0;
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      core_key_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      mismatch_q   <= 1'b0;
      ff_idx_q     <= '0;
      ff_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cur_idx_q    <= cur_idx_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      core_key_q   <= core_key_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      mismatch_q   <= mismatch_d;
      ff_idx_q     <= ff_idx_d;
      ff_vld_q     <= ff_vld_d;
    end
  end

  assign core_data      = core_data_q;
  assign core_key       = core_key_q;
  assign core_valid     = core_valid_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign mismatch       = mismatch_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_aes_vector_checker.sv
// tb/tb_aes_vector_checker.sv - directed bench for aes_vector_checker
module tb_aes_vector_checker;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data, wr_key, wr_exp;
  logic [4:0]   num_vec;
  logic         start;

  logic [127:0] core_data0, core_key0, core_result0;
  logic         core_valid0, busy0, done0, mismatch0, ffvld0;
  logic [4:0]   pass0, fail0;
  logic [3:0]   ffidx0;

  logic [127:0] core_data1, core_key1, core_result1;
  logic         core_valid1, busy1, done1, mismatch1, ffvld1;
  logic [4:0]   pass1, fail1;
  logic [3:0]   ffidx1;

  logic [127:0] c1_s1, c1_s2, c1_s3;

  int checks = 0;
  int errors = 0;

  int k_done0, k_done1, vcnt0, vcnt1, vfirst0, vlast0, mm0, mm1, k_pass1, pass0_k1;
  logic [127:0] data0_k1;

  always #5 clk = ~clk;

  // Stand-in core: the FIPS-197 vector maps to its known ciphertext,
  // anything else to pt ^ key.
  function automatic logic [127:0] fake_aes(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ key;
  endfunction

  function automatic logic [127:0] pat_pt(input int i);
    return {4{32'hA5A5_0000 | 32'(i)}};
  endfunction

  function automatic logic [127:0] pat_key(input int i);
    return {4{32'h0F0F_0000 + 32'(i * 3)}};
  endfunction

  assign core_result0 = fake_aes(core_data0, core_key0);

  always @(posedge clk) begin
    c1_s1 <= fake_aes(core_data1, core_key1);
    c1_s2 <= c1_s1;
    c1_s3 <= c1_s2;
  end
  assign core_result1 = c1_s3;

  aes_vector_checker #(.DATA_W(128), .KEY_W(128), .DEPTH(16), .ADDR_W(4), .CORE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_key(wr_key), .wr_exp(wr_exp), .num_vec(num_vec), .start(start),
    .core_data(core_data0), .core_key(core_key0), .core_valid(core_valid0),
    .core_result(core_result0), .busy(busy0), .done(done0), .pass_cnt(pass0),
    .fail_cnt(fail0), .mismatch(mismatch0), .first_fail_idx(ffidx0), .first_fail_vld(ffvld0)
  );

  aes_vector_checker #(.DATA_W(128), .KEY_W(128), .DEPTH(16), .ADDR_W(4), .CORE_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_key(wr_key), .wr_exp(wr_exp), .num_vec(num_vec), .start(start),
    .core_data(core_data1), .core_key(core_key1), .core_valid(core_valid1),
    .core_result(core_result1), .busy(busy1), .done(done1), .pass_cnt(pass1),
    .fail_cnt(fail1), .mismatch(mismatch1), .first_fail_idx(ffidx1), .first_fail_vld(ffvld1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = pt; wr_key = key; wr_exp = exp;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Launch a run and watch both instances cycle by cycle; k counts cycles
  // after the start edge (k = 1 is the first cycle of the run).
  task automatic run(input logic [4:0] n, input int max_k, input int start_at,
                     input int wr_at, input bit wr_same);
    k_done0 = -1; k_done1 = -1; vcnt0 = 0; vcnt1 = 0; vfirst0 = -1; vlast0 = -1;
    mm0 = 0; mm1 = 0; k_pass1 = -1; pass0_k1 = -1; data0_k1 = '0;
    @(negedge clk);
    num_vec = n; start = 1'b1; wr_en = wr_same;
    @(posedge clk);
    #1;
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (core_valid0) begin
        vcnt0++;
        if (vfirst0 < 0) vfirst0 = k;
        vlast0 = k;
      end
      if (core_valid1) vcnt1++;
      if (mismatch0) mm0++;
      if (mismatch1) mm1++;
      if (done0 && k_done0 < 0) k_done0 = k;
      if (done1 && k_done1 < 0) k_done1 = k;
      if (pass1 != 0 && k_pass1 < 0) k_pass1 = k;
      if (k == 1) begin
        pass0_k1 = int'(pass0);
        data0_k1 = core_data0;
      end
      if (k == start_at) begin
        start = 1'b1; num_vec = 5'd2;
      end
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = '1; wr_key = '1; wr_exp = 128'h1234;
      end
      if (k_done0 >= 0 && k_done1 >= 0) break;
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_key = '0; wr_exp = '0;
    num_vec = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_valid", int'(core_valid0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_fail", int'(fail0), 0);
    chk("rst_ffvld", int'(ffvld0), 0);
    chk("rst_ffidx", int'(ffidx0), 0);
    chk("rst_mismatch", int'(mismatch0), 0);
    chk_w("rst_data", core_data0, '0);
    chk_w("rst_key", core_key0, '0);
    rst = 1'b0;

    // FIPS-197 single vector
    load(0, FIPS_PT, FIPS_KEY, FIPS_CT);
    run(5'd1, 30, -1, -1, 1'b0);
    chk("fips_vcnt", vcnt0, 1);
    chk("fips_vfirst", vfirst0, 1);
    chk("fips_done_k", k_done0, 2);
    chk("fips_pass", int'(pass0), 1);
    chk("fips_fail", int'(fail0), 0);
    chk("fips_ffvld", int'(ffvld0), 0);
    chk("fips_lat_done_k", k_done1, 5);
    chk("fips_lat_pass", int'(pass1), 1);

    // Full depth, slot 5 expected value has bit 0 flipped
    for (int i = 0; i < 16; i++) begin
      load(i, pat_pt(i), pat_key(i), (pat_pt(i) ^ pat_key(i)) ^ ((i == 5) ? 128'd1 : 128'd0));
    end
    run(5'd16, 40, -1, -1, 1'b0);
    chk("full_vcnt", vcnt0, 16);
    chk("full_vfirst", vfirst0, 1);
    chk("full_vlast", vlast0, 16);
    chk("full_done_k", k_done0, 17);
    chk("full_pass", int'(pass0), 15);
    chk("full_fail", int'(fail0), 1);
    chk("full_ffidx", int'(ffidx0), 5);
    chk("full_ffvld", int'(ffvld0), 1);
    chk("full_mm", mm0, 1);
    chk("full_lat_done_k", k_done1, 20);
    chk("full_lat_pass", int'(pass1), 15);
    chk("full_lat_ffidx", int'(ffidx1), 5);
    chk("full_lat_mm", mm1, 1);

    // Latency 3, four vectors
    load(5, pat_pt(5), pat_key(5), pat_pt(5) ^ pat_key(5));
    run(5'd4, 30, -1, -1, 1'b0);
    chk("lat_done_k", k_done1, 8);
    chk("lat_pass", int'(pass1), 4);
    chk("lat_first_pass_k", k_pass1, 5);
    chk("lat_vcnt", vcnt1, 4);
    chk("lat0_done_k", k_done0, 5);

    // Restart from DONE
    run(5'd4, 30, -1, -1, 1'b0);
    chk("restart_clear", pass0_k1, 0);
    chk("restart_pass", int'(pass0), 4);
    chk("restart_done_k", k_done0, 5);
    chk("restart_lat_done_k", k_done1, 8);

    // num_vec = 0
    run(5'd0, 30, -1, -1, 1'b0);
    chk("zero_done_k", k_done0, 1);
    chk("zero_vcnt", vcnt0, 0);
    chk("zero_pass", int'(pass0), 0);
    chk("zero_fail", int'(fail0), 0);
    chk("zero_lat_done_k", k_done1, 1);
    chk("zero_lat_vcnt", vcnt1, 0);

    // num_vec = 20 clamps to 16
    run(5'd20, 40, -1, -1, 1'b0);
    chk("clamp_vcnt", vcnt0, 16);
    chk("clamp_done_k", k_done0, 17);
    chk("clamp_pass", int'(pass0), 16);
    chk("clamp_fail", int'(fail0), 0);

    // start pulsed during ISSUE is ignored
    run(5'd8, 40, 3, -1, 1'b0);
    chk("restart_ign_vcnt", vcnt0, 8);
    chk("restart_ign_done_k", k_done0, 9);
    chk("restart_ign_pass", int'(pass0), 8);
    chk("restart_ign_lat_pass", int'(pass1), 8);

    // Write while busy leaves memory untouched
    run(5'd16, 40, -1, 3, 1'b0);
    chk("busywr_pass", int'(pass0), 16);
    run(5'd16, 40, -1, -1, 1'b0);
    chk("busywr_rerun_pass", int'(pass0), 16);
    chk("busywr_rerun_fail", int'(fail0), 0);
    chk("busywr_rerun_lat_pass", int'(pass1), 16);

    // Write in the same cycle as start: run sees the new slot 0
    wr_addr = 4'd0; wr_data = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    wr_key = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    wr_exp = wr_data ^ wr_key;
    run(5'd1, 30, -1, -1, 1'b1);
    chk_w("bypass_data", data0_k1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    chk("bypass_pass", int'(pass0), 1);
    chk("bypass_fail", int'(fail0), 0);
    chk("bypass_lat_pass", int'(pass1), 1);

    // Reset mid-run with slot 5 corrupted and its compare still in flight
    load(5, pat_pt(5), pat_key(5), (pat_pt(5) ^ pat_key(5)) ^ 128'd1);
    @(negedge clk);
    num_vec = 5'd16; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_pre_valid", int'(core_valid0), 1);
    chk("midrst_pre_pass", int'(pass0), 6);
    chk("midrst_pre_fail", int'(fail0), 1);
    chk("midrst_pre_lat_pass", int'(pass1), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_done", int'(done0), 0);
    chk("midrst_pass", int'(pass0), 0);
    chk("midrst_fail", int'(fail0), 0);
    chk("midrst_valid", int'(core_valid0), 0);
    chk("midrst_lat_busy", int'(busy1), 0);
    mm0 = 0; mm1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mismatch0) mm0++;
      if (mismatch1) mm1++;
    end
    chk("midrst_post_mm", mm0, 0);
    chk("midrst_post_lat_mm", mm1, 0);
    chk("midrst_post_lat_pass", int'(pass1), 0);
    chk("midrst_post_lat_fail", int'(fail1), 0);
    run(5'd16, 40, -1, -1, 1'b0);
    chk("postrst_vcnt", vcnt0, 16);
    chk("postrst_pass", int'(pass0), 15);
    chk("postrst_fail", int'(fail0), 1);
    chk("postrst_ffidx", int'(ffidx0), 5);
    chk("postrst_lat_pass", int'(pass1), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
